// File: rtl/mux_n_1_rr_if.sv
// Handshake bus for the N:1 round-robin / fixed-select output mux.
// master = upstream/downstream environment, slave = the mux itself.
interface mux_n_1_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      mode;
    logic [SW-1:0]             sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SW-1:0]             out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_n_1_rr.sv
// N:1 mux with a single registered output slot. Channel picked either by
// a fixed sel or by a round-robin pointer that advances past every winner.
module mux_n_1_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_n_1_rr_if.slave    bus
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] ptr, ptr_nxt;
    logic [SW-1:0] g;
    logic          gnt_vld;
    logic [WIDTH-1:0] g_data;
    logic          slot_free;
    logic          xfer;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    sel_q;

    // Grant: fixed sel (out-of-range sel never matches) or rotating search from ptr.
    // RR loop runs from the farthest offset down so the nearest valid wins last.
    always_comb begin
        g       = '0;
        gnt_vld = 1'b0;
        if (!bus.mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.sel == SW'(k) && bus.in_valid[k]) begin
                    g       = SW'(k);
                    gnt_vld = 1'b1;
                end
            end
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (((int'(ptr) + i) % CHANNELS) == k && bus.in_valid[k]) begin
                        g       = SW'(k);
                        gnt_vld = 1'b1;
                    end
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        g_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (g == SW'(k)) g_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // Slot accepts when empty or draining this cycle; reset blocks any accept.
    assign slot_free = (state == EMPTY) || bus.out_ready;
    assign xfer      = rst_n && gnt_vld && slot_free;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_rdy
        assign bus.in_ready[k] = xfer && (g == SW'(k));
    end

    // Next state of the output slot and the round-robin pointer.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            EMPTY: if (xfer) state_nxt = FULL;
            FULL: begin
                if (xfer)               state_nxt = FULL;
                else if (bus.out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
        if (xfer) ptr_nxt = (g == SW'(CHANNELS - 1)) ? '0 : g + 1'b1;
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Output word register: loads on every transfer, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (xfer) begin
            data_q <= g_data;
            sel_q  <= g;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: accepted words are queued at the
// handshake and compared against the output register until drained.
module tb_mux_n_1_rr;
    localparam int W  = 4;
    localparam int C  = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [W-1:0]  d;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_n_1_rr_if #(.WIDTH(W), .CHANNELS(C)) bus ();
    mux_n_1_rr #(.WIDTH(W), .CHANNELS(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    word_t         sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [SW-1:0] m_ptr;
    logic          m_full;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference grant: fixed sel, or first valid channel walking up from m_ptr.
    task automatic model_grant(input logic md, input logic [SW-1:0] s,
                               input logic [C-1:0] v,
                               output logic ok, output logic [SW-1:0] gg);
        ok = 1'b0;
        gg = '0;
        if (!md) begin
            if (v[s]) begin ok = 1'b1; gg = s; end
        end else begin
            for (int off = 0; off < C; off++) begin
                int c;
                c = (int'(m_ptr) + off) % C;
                if (!ok && v[c]) begin ok = 1'b1; gg = SW'(c); end
            end
        end
    endtask

    // One clock cycle; entered just after a falling edge.
    task automatic cyc(input logic md, input logic [SW-1:0] s, input logic [C-1:0] v,
                       input logic ordy, input logic [C*W-1:0] d);
        logic          ok;
        logic [SW-1:0] gg;
        logic [C-1:0]  exp_rdy;
        bus.mode      = md;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        bus.in_data   = d;
        #1;
        model_grant(md, s, v, ok, gg);
        exp_rdy = (ok && (!m_full || ordy)) ? (C'(1) << gg) : '0;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (m_full) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(sb[0].d));
                chk("out_sel",  32'(bus.out_sel),  32'(sb[0].ch));
                if (ordy) void'(sb.pop_front());
            end
        end
        if (exp_rdy != '0) begin
            sb.push_back({gg, d[int'(gg)*W +: W]});
            m_ptr = (gg == SW'(C - 1)) ? '0 : gg + 1'b1;
        end
        m_full = (exp_rdy != '0) || (m_full && !ordy);
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.in_valid  = '1;
        bus.in_data   = 16'h1234;
        bus.out_ready = 1'b1;
        m_ptr         = '0;
        m_full        = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness from reset: 0,1,2,3,0 back to back.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, '0, 4'b1111, 1'b1, 16'($urandom));
            chk("rr_seq", 32'(bus.out_sel), 32'(i % C));
        end

        // Fixed select of channel 2 carrying 4'hA.
        cyc(1'b0, 2'd2, 4'b1111, 1'b1, 16'h3A21);
        chk("fix_data", 32'(bus.out_data), 32'hA);
        chk("fix_sel",  32'(bus.out_sel),  32'd2);

        // ptr is now 3: skip to channel 1, then wrap to channel 0.
        cyc(1'b1, '0, 4'b0010, 1'b1, 16'h4567);
        chk("skip_sel", 32'(bus.out_sel), 32'd1);
        cyc(1'b1, '0, 4'b0001, 1'b1, 16'h89AB);
        chk("wrap_sel", 32'(bus.out_sel), 32'd0);

        // Backpressure for 3 cycles, then drain and reload on the same edge.
        for (int i = 0; i < 3; i++) cyc(1'b1, '0, 4'b1111, 1'b0, 16'($urandom));
        cyc(1'b1, '0, 4'b1111, 1'b1, 16'hCDEF);
        chk("bp_reload_valid", 32'(bus.out_valid), 32'd1);

        // Fixed-mode miss: sel points at an idle channel; slot drains empty.
        cyc(1'b0, 2'd1, 4'b1101, 1'b1, 16'($urandom));
        cyc(1'b0, 2'd1, 4'b1101, 1'b1, 16'($urandom));
        chk("miss_empty", 32'(bus.out_valid), 32'd0);

        // Mixed traffic.
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom), SW'($urandom), C'($urandom), ($urandom_range(0, 3) != 0),
                16'($urandom));

        // Reset between edges while full.
        cyc(1'b1, '0, 4'b1111, 1'b0, 16'h5555);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(bus.out_valid), 32'd0);
        chk("mid_rst_data",     32'(bus.out_data),  32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
        sb.delete();
        m_full = 1'b0;
        m_ptr  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, '0, 4'b1111, 1'b1, 16'h7654);
        chk("rst_restart_sel", 32'(bus.out_sel), 32'd0);
        cyc(1'b1, '0, 4'b1111, 1'b1, 16'h3210);
        chk("rst_next_sel", 32'(bus.out_sel), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_n_1_rr.md
MUX_N_1_RR -- requirements
Module: mux_n_1_rr

Interface
REQ-001 Parameter WIDTH, default 4: data bits per channel, legal range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 2..8; SW = max(1, clog2(CHANNELS)).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  0 = fixed select (sel), 1 = round-robin.
REQ-006 sel  input  SW  channel to forward in fixed mode.
REQ-007 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel data valid.
REQ-009 in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_sel  output  SW  index of the channel that produced out_data.
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_ready  input  1  downstream accepts.

Function
REQ-014 The block SHALL hold a single output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 The slot SHALL be "free" in a cycle when out_valid=0 or out_ready=1.
REQ-016 Grant g SHALL be computed combinationally each cycle.
  - mode=0: g=sel if in_valid[sel]=1 and sel<CHANNELS; otherwise no grant.
  - mode=1: g = first k with in_valid[k]=1, searching from ptr upward with wrap at CHANNELS-1 -> 0.
REQ-017 in_ready[g] SHALL be 1 only when a grant exists and the slot is free; all other in_ready bits SHALL be 0.
REQ-018 The block SHALL transfer on channel g when in_valid[g] and in_ready[g] are both 1. On the next edge: out_data=in_data[g], out_sel=g, out_valid=1.
REQ-019 If out_valid=1, out_ready=1 and there is no transfer, out_valid SHALL go to 0. out_data and out_sel SHALL hold their values.
REQ-020 If out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold. No input SHALL be accepted.
REQ-021 Simultaneous drain and transfer (FULL, out_ready=1, grant present) SHALL reload the register in the same edge, sustaining one word per cycle with no bubble.
REQ-022 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-023 Round-robin pointer ptr (SW bits) SHALL update to (g+1) mod CHANNELS on every transfer, in either mode. It SHALL be unchanged otherwise.
REQ-024 A mode or sel change SHALL take effect in the same cycle's grant. It SHALL NOT disturb a word already in the output register.
REQ-025 in_valid bits for a non-granted channel SHALL have no effect on state.
REQ-026 The block SHALL never drop or duplicate a word: each out_valid&out_ready handshake corresponds to exactly one prior input transfer.

Reset
REQ-027 While rst_n=0, the block SHALL force out_valid=0, out_data=0, out_sel=0, ptr=0 and in_ready=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard any held word. After rst_n deasserts, the first transfer SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-029 Fixed mode: CHANNELS=4, mode=0, sel=2, in_valid=4'b1111, channel 2 data=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_data=4'hA, out_sel=2, out_valid=1.
REQ-030 Round-robin fairness: mode=1, in_valid=4'b1111 constant, out_ready=1 from reset -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid held at 1.
REQ-031 Skip and wrap: mode=1, ptr=3, in_valid=4'b0010 -> grant channel 1, ptr becomes 2. A following in_valid=4'b0001 -> grant channel 0.
REQ-032 Backpressure: FULL with out_ready=0 for 3 cycles, all in_valid=1 -> in_ready=0 and out_data stable for all 3 cycles. On out_ready=1, the next word loads on the same edge as the drain.
REQ-033 Fixed-mode miss: mode=0, sel=1, in_valid=4'b1101 -> in_ready=0; out_valid falls to 0 after the current word drains.
REQ-034 Reset mid-stream: rst_n pulled low between edges while FULL -> out_valid=0 and out_data=0 immediately. After release, ptr=0 and round-robin restarts at channel 0.
